// File: rtl/seg7_handle.sv
// Four-digit multiplexed 7-segment driver: clamps a 14-bit value to 9999,
// converts it to BCD and scans the digits with a free-running refresh counter.
module seg7_handle #(
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] num,
  output logic [6:0]  controls,
  output logic [3:0]  seg_ctrl,
  output logic [3:0]  out_seg
);

  localparam int unsigned NUM_W   = 14;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned SHIFT_W = NUM_W + BCD_W;
  localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(9999);

  logic [NUM_W-1:0]        num_q;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              idx;
  logic [BCD_W-1:0]        bcd;
  logic [SHIFT_W-1:0]      dd;

  // Input capture with clamp so the BCD conversion never exceeds four digits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_q <= '0;
    end else begin
      num_q <= (num > NUM_MAX) ? NUM_MAX : num;
    end
  end

  // Refresh counter; the digit index steps on each wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      if (refresh_cnt == '1) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Double dabble: adjust each BCD nibble >= 5 by +3, then shift in one binary bit
  always_comb begin
    dd = {BCD_W'(0), num_q};
    for (int i = 0; i < int'(NUM_W); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (dd[NUM_W + 4*d +: 4] >= 4'd5) begin
          dd[NUM_W + 4*d +: 4] = dd[NUM_W + 4*d +: 4] + 4'd3;
        end
      end
      dd = {dd[SHIFT_W-2:0], 1'b0};
    end
    bcd = dd[SHIFT_W-1:NUM_W];
  end

  // Digit select and anode drive
  always_comb begin
    out_seg  = bcd[3:0];
    seg_ctrl = ~(4'b0001 << idx);
    case (idx)
      2'd0: out_seg = bcd[3:0];
      2'd1: out_seg = bcd[7:4];
      2'd2: out_seg = bcd[11:8];
      2'd3: out_seg = bcd[15:12];
      default: out_seg = bcd[3:0];
    endcase
  end

  // Active-low segment decode {g,f,e,d,c,b,a}; non-decimal codes blank
  always_comb begin
    controls = 7'b1111111;
    case (out_seg)
      4'd0: controls = 7'b1000000;
      4'd1: controls = 7'b1111001;
      4'd2: controls = 7'b0100100;
      4'd3: controls = 7'b0110000;
      4'd4: controls = 7'b0011001;
      4'd5: controls = 7'b0010010;
      4'd6: controls = 7'b0000010;
      4'd7: controls = 7'b1111000;
      4'd8: controls = 7'b0000000;
      4'd9: controls = 7'b0010000;
      default: controls = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_seg7_handle.sv
// Randomized self-checking bench for seg7_handle against an arithmetic
// (divide/modulo) model of the displayed digit, with REFRESH_BITS=2.
module tb_seg7_handle;

  localparam int unsigned RB   = 2;
  localparam int          SLOT = 1 << RB;

  logic        clock;
  logic        reset;
  logic [13:0] num;
  logic [6:0]  controls;
  logic [3:0]  seg_ctrl;
  logic [3:0]  out_seg;

  int n_checks;
  int n_pass;
  int cyc;   // rising edges seen since reset release
  int nq;    // model of the captured, clamped value

  logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  logic [3:0] anode_lut [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         pow10 [4]     = '{1, 10, 100, 1000};

  seg7_handle #(.REFRESH_BITS(RB)) dut (
    .clock    (clock),
    .reset    (reset),
    .num      (num),
    .controls (controls),
    .seg_ctrl (seg_ctrl),
    .out_seg  (out_seg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  function automatic int exp_idx();
    return (cyc / SLOT) % 4;
  endfunction

  task automatic check_all(input string ctx);
    int i;
    int dig;
    i   = exp_idx();
    dig = (nq / pow10[i]) % 10;
    check({ctx, ".seg_ctrl"}, int'(seg_ctrl), int'(anode_lut[i]));
    check({ctx, ".out_seg"},  int'(out_seg),  dig);
    check({ctx, ".controls"}, int'(controls), int'(seg_lut[dig]));
  endtask

  // Drive num away from the edge, check the old value still shows, clock once, check again
  task automatic step(input int n, input string ctx);
    num = 14'(n);
    #1 check_all({ctx, ".pre"});
    @(posedge clock);
    if (reset) begin
      cyc++;
      nq = (n > 9999) ? 9999 : n;
    end
    @(negedge clock);
    check_all({ctx, ".post"});
  endtask

  task automatic do_reset(input string ctx);
    #2 reset = 1'b0;
    #1;
    cyc = 0;
    nq  = 0;
    check({ctx, ".rst_seg_ctrl"}, int'(seg_ctrl), int'(4'b1110));
    check({ctx, ".rst_out_seg"},  int'(out_seg),  0);
    check({ctx, ".rst_controls"}, int'(controls), int'(7'b1000000));
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int guard;
    int val;
    int hold;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    nq       = 0;

    // Reset held before any clock edge
    reset = 1'b0;
    num   = 14'd3566;
    #1;
    check("por.seg_ctrl", int'(seg_ctrl), int'(4'b1110));
    check("por.out_seg",  int'(out_seg),  0);
    check("por.controls", int'(controls), int'(7'b1000000));
    check_all("por");

    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 17; k++) step(3566, "d3566");
    for (int k = 0; k < 16; k++) step(7432, "d7432");
    for (int k = 0; k < 16; k++) step(54, "d54");
    for (int k = 0; k < 16; k++) step(16383, "dclamp");
    check("dclamp.controls9", int'(controls), int'(7'b0010000));

    // Mid-scan change: get to the first clock of the tens slot with num=10
    guard = 0;
    step(10, "mid10");
    while ((cyc % (4 * SLOT)) != SLOT && guard < 64) begin
      step(10, "mid10");
      guard++;
    end
    check("mid.reached_tens", guard < 64 ? 1 : 0, 1);
    check("mid.tens_before", int'(out_seg), 1);
    step(609, "mid609");
    check("mid.tens_after", int'(out_seg), 0);
    check("mid.still_tens", int'(seg_ctrl), int'(4'b1101));
    for (int k = 0; k < 8; k++) step(609, "mid609");

    // Reset mid-scan returns to the ones digit without a clock
    for (int k = 0; k < 6; k++) step(8888, "pre_rst");
    do_reset("midrst");
    for (int k = 0; k < 5; k++) step(1234, "post_rst");

    // Randomized values, hold lengths and occasional resets
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: val = $urandom_range(0, 9);
        1: val = $urandom_range(9990, 16383);
        default: val = $urandom_range(0, 16383);
      endcase
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) step(val, "rnd");
      if ($urandom_range(0, 19) == 0) do_reset("rndrst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
